// File: rtl/pacer_pkg.sv
// Shared types and helpers for cdc_pulse_pacer.
// FSM encoding, drop-counter width and gap-timer sizing.
package pacer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFire = 2'd1,
    StWait = 2'd2
  } state_e;

  localparam int unsigned DropCntW = 8;

  function automatic int unsigned gap_cnt_w(int unsigned gap_cycles);
    return $clog2(gap_cycles + 1);
  endfunction

endpackage

// File: rtl/cdc_pulse_pacer_if.sv
// Event/status bundle between the pacer and its fast-domain client.
// drop_cnt is present only when PACER_DROP_CNT_EN is defined.
interface cdc_pulse_pacer_if #(
  parameter int unsigned CNT_W = 4
);

  logic             evt_in;
  logic             clr_ovf;
  logic             pulse_out;
  logic             busy;
  logic [CNT_W-1:0] pending;
  logic             overflow;
`ifdef PACER_DROP_CNT_EN
  logic [pacer_pkg::DropCntW-1:0] drop_cnt;
`endif

  modport master (
    output evt_in,
    output clr_ovf,
`ifdef PACER_DROP_CNT_EN
    input  drop_cnt,
`endif
    input  pulse_out,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  evt_in,
    input  clr_ovf,
`ifdef PACER_DROP_CNT_EN
    output drop_cnt,
`endif
    output pulse_out,
    output busy,
    output pending,
    output overflow
  );

endinterface

// File: rtl/cdc_pulse_pacer.sv
// Queues event strobes and re-issues them as single-cycle pulses spaced GAP_CYCLES+1 apart.
// Optional saturating drop counter enabled by PACER_DROP_CNT_EN.
module cdc_pulse_pacer
  import pacer_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned CNT_W      = 4
) (
  input logic               clka,
  input logic               rstn,
  cdc_pulse_pacer_if.slave  bus
);

  localparam int unsigned      GapW    = gap_cnt_w(GAP_CYCLES);
  localparam logic [GapW-1:0]  GapLoad = GapW'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] PendMax = '1;

  state_e           r_state;
  state_e           w_state_d;
  logic [GapW-1:0]  r_gap;
  logic [GapW-1:0]  w_gap_d;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] w_pending_d;
  logic             r_pulse;
  logic             r_ovf;
  logic             w_ovf_d;
  logic             w_fire;
  logic             w_inc;
  logic             w_drop;

  // WAIT holds for exactly GAP_CYCLES cycles: leave on the edge the counter hits 0.
  always_comb begin
    w_state_d = r_state;
    w_gap_d   = r_gap;
    unique case (r_state)
      StIdle: begin
        if (r_pending != '0) w_state_d = StFire;
      end
      StFire: begin
        w_state_d = StWait;
        w_gap_d   = GapLoad;
      end
      StWait: begin
        if (r_gap <= GapW'(1)) begin
          w_gap_d   = '0;
          w_state_d = (r_pending != '0) ? StFire : StIdle;
        end else begin
          w_gap_d = r_gap - GapW'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_gap_d   = '0;
      end
    endcase
  end

  assign w_fire = (w_state_d == StFire);
  assign w_inc  = bus.evt_in;
  assign w_drop = w_inc && !w_fire && (r_pending == PendMax);

  always_comb begin
    w_pending_d = r_pending;
    if (w_inc && !w_fire && !w_drop) begin
      w_pending_d = r_pending + CNT_W'(1);
    end else if (!w_inc && w_fire) begin
      w_pending_d = r_pending - CNT_W'(1);
    end
  end

  always_comb begin
    w_ovf_d = r_ovf;
    if (w_drop) begin
      w_ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      w_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_gap     <= '0;
      r_pending <= '0;
      r_pulse   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_gap     <= w_gap_d;
      r_pending <= w_pending_d;
      r_pulse   <= w_fire;
      r_ovf     <= w_ovf_d;
    end
  end

`ifdef PACER_DROP_CNT_EN
  logic [DropCntW-1:0] r_drop_cnt;
  logic [DropCntW-1:0] w_drop_cnt_d;

  // A drop coinciding with a clear restarts the count at 1.
  always_comb begin
    w_drop_cnt_d = r_drop_cnt;
    if (w_drop) begin
      if (bus.clr_ovf) begin
        w_drop_cnt_d = DropCntW'(1);
      end else if (r_drop_cnt != '1) begin
        w_drop_cnt_d = r_drop_cnt + DropCntW'(1);
      end
    end else if (bus.clr_ovf) begin
      w_drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clka or negedge rstn) begin
    if (!rstn) begin
      r_drop_cnt <= '0;
    end else begin
      r_drop_cnt <= w_drop_cnt_d;
    end
  end

  assign bus.drop_cnt = r_drop_cnt;
`endif

  assign bus.pulse_out = r_pulse;
  assign bus.busy      = (r_state != StIdle) || (r_pending != '0);
  assign bus.pending   = r_pending;
  assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_cdc_pulse_pacer.sv
// Self-checking bench for cdc_pulse_pacer (GAP_CYCLES=4, CNT_W=3) against a timing-based model.
// Checks drop_cnt too when PACER_DROP_CNT_EN is defined.
module tb_cdc_pulse_pacer;

  localparam int unsigned Gap  = 4;
  localparam int unsigned CntW = 3;
  localparam int          Max  = 7;

  logic clka;
  logic rstn;
  int   n_checks;
  int   n_pass;

  cdc_pulse_pacer_if #(.CNT_W(CntW)) u_if ();

  cdc_pulse_pacer #(
    .GAP_CYCLES (Gap),
    .CNT_W      (CntW)
  ) u_dut (
    .clka (clka),
    .rstn (rstn),
    .bus  (u_if)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  // Model: a pulse may fire once pending>0 and GAP+1 edges have passed since the last one.
  int cyc;
  int m_pend;
  int m_last;
  int m_drop;
  bit m_ovf;
  bit m_pulse;
  bit m_busy;

  task automatic m_reset();
    m_pend  = 0;
    m_last  = -1000;
    m_drop  = 0;
    m_ovf   = 0;
    m_pulse = 0;
    m_busy  = 0;
  endtask

  task automatic m_step(input bit evt, input bit clr);
    bit fire;
    bit dropped;
    cyc++;
    fire    = (m_pend > 0) && (cyc >= m_last + int'(Gap) + 1);
    dropped = evt && !fire && (m_pend == Max);
    if (!dropped) m_pend = m_pend + int'(evt) - int'(fire);
    if (fire) m_last = cyc;
    m_pulse = (m_last == cyc);
    m_busy  = (m_pend > 0) || (cyc <= m_last + int'(Gap));
    if (dropped) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (dropped) m_drop = clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    else if (clr) m_drop = 0;
  endtask

  function automatic logic [5:0] exp_vec();
    logic [CntW-1:0] p;
    p = CntW'(m_pend);
    return {m_pulse, m_busy, p, m_ovf};
  endfunction

  function automatic logic [5:0] act_vec();
    return {u_if.pulse_out, u_if.busy, u_if.pending, u_if.overflow};
  endfunction

  task automatic step(input logic evt, input logic clr);
    u_if.evt_in  = evt;
    u_if.clr_ovf = clr;
    @(posedge clka);
    m_step(evt, clr);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    u_if.evt_in  = 1'b0;
    u_if.clr_ovf = 1'b0;
    m_reset();
    for (int i = 0; i < 6; i++) begin
      u_if.evt_in = 1'($urandom);
      @(posedge clka);
      #1;
      n_checks++;
      if (act_vec() !== 6'b0) $display("FAIL reset_hold: got %b want %b", act_vec(), 6'b0);
      else n_pass++;
    end
    u_if.evt_in = 1'b0;
    @(negedge clka);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (act_vec() !== 6'b0) $display("FAIL reset_release: got %b want %b", act_vec(), 6'b0);
      else n_pass++;
    end
  endtask

  task automatic test_single_event();
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    n_checks++;
    if (u_if.pending !== 3'd1) $display("FAIL single_pend: got %0d want 1", u_if.pending);
    else n_pass++;
    for (int k = 11; k <= 16; k++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if ({u_if.pulse_out, u_if.busy, u_if.pending} !== {(k == 11), (k < 16), 3'd0})
        $display("FAIL single_e%0d: got p=%b b=%b n=%0d want p=%b b=%b n=0", k,
                 u_if.pulse_out, u_if.busy, u_if.pending, (k == 11), (k < 16));
      else n_pass++;
      n_checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL single_model: got %b want %b", act_vec(), exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_burst();
    int rises[$];
    for (int k = 0; k <= 16; k++) begin
      step(k <= 2, 1'b0);
      if (u_if.pulse_out) rises.push_back(k);
      n_checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL burst_model_e%0d: got %b want %b", k, act_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (rises.size() != 3 || rises[0] != 1 || rises[1] != 6 || rises[2] != 11)
      $display("FAIL burst_rises: got %p want '{1,6,11}", rises);
    else n_pass++;
    n_checks++;
    if ({u_if.busy, u_if.overflow} !== 2'b00)
      $display("FAIL burst_end: got busy=%b ovf=%b want 0 0", u_if.busy, u_if.overflow);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int pulses = 0;
    for (int k = 0; k < 80; k++) begin
      step(k <= 11, 1'b0);
      if (u_if.pulse_out) pulses++;
      if (k == 8 || k == 11) begin
        n_checks++;
        if (u_if.pending !== 3'd7) $display("FAIL sat_pend_e%0d: got %0d want 7", k, u_if.pending);
        else n_pass++;
      end
      if (k == 8 || k == 9) begin
        n_checks++;
        if (u_if.overflow !== (k == 9)) $display("FAIL sat_ovf_e%0d: got %b want %b", k,
                                                 u_if.overflow, (k == 9));
        else n_pass++;
      end
      n_checks++;
      if (act_vec() !== exp_vec())
        $display("FAIL sat_model_e%0d: got %b want %b", k, act_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (pulses != 10) $display("FAIL sat_pulses: got %0d want 10", pulses);
    else n_pass++;
`ifdef PACER_DROP_CNT_EN
    n_checks++;
    if (u_if.drop_cnt !== 8'd2) $display("FAIL sat_dropcnt: got %0d want 2", u_if.drop_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_clear_race();
    step(1'b0, 1'b1);
    n_checks++;
    if (u_if.overflow !== 1'b0) $display("FAIL clr_pre: got %b want 0", u_if.overflow);
    else n_pass++;
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0);
    for (int k = 0; k <= 9; k++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    n_checks++;
    if (u_if.overflow !== 1'b1) $display("FAIL clr_race_ovf: got %b want 1", u_if.overflow);
    else n_pass++;
`ifdef PACER_DROP_CNT_EN
    n_checks++;
    if (u_if.drop_cnt !== 8'd1) $display("FAIL clr_race_dcnt: got %0d want 1", u_if.drop_cnt);
    else n_pass++;
`endif
    step(1'b0, 1'b1);
    n_checks++;
    if (u_if.overflow !== 1'b0) $display("FAIL clr_alone_ovf: got %b want 0", u_if.overflow);
    else n_pass++;
`ifdef PACER_DROP_CNT_EN
    n_checks++;
    if (u_if.drop_cnt !== 8'd0) $display("FAIL clr_alone_dcnt: got %0d want 0", u_if.drop_cnt);
    else n_pass++;
`endif
    for (int k = 0; k < 50; k++) step(1'b0, 1'b0);
    n_checks++;
    if (act_vec() !== exp_vec()) $display("FAIL clr_drain: got %b want %b", act_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 6; k++) step(1'b1, 1'b0);
    n_checks++;
    if ({u_if.pending, u_if.pulse_out} !== {3'd5, 1'b0})
      $display("FAIL midrst_pre: got n=%0d p=%b want n=5 p=0", u_if.pending, u_if.pulse_out);
    else n_pass++;
    u_if.evt_in = 1'b0;
    #2;
    rstn = 1'b0;
    m_reset();
    #1;
    n_checks++;
    if (act_vec() !== 6'b0) $display("FAIL midrst_async: got %b want %b", act_vec(), 6'b0);
    else n_pass++;
    @(negedge clka);
    rstn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 1'b0);
      n_checks++;
      if (act_vec() !== 6'b0) $display("FAIL midrst_idle_e%0d: got %b want 0", k, act_vec());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int pct;
    for (int blk = 0; blk < 8; blk++) begin
      pct = $urandom_range(5, 95);
      for (int k = 0; k < 60; k++) begin
        step($urandom_range(0, 99) < pct, $urandom_range(0, 15) == 0);
        n_checks++;
        if (act_vec() !== exp_vec())
          $display("FAIL rand_b%0d_c%0d: got %b want %b", blk, k, act_vec(), exp_vec());
        else n_pass++;
`ifdef PACER_DROP_CNT_EN
        n_checks++;
        if (u_if.drop_cnt !== 8'(m_drop))
          $display("FAIL rand_dcnt: got %0d want %0d", u_if.drop_cnt, m_drop);
        else n_pass++;
`endif
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    test_reset();
    test_single_event();
    test_burst();
    test_saturation();
    test_clear_race();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
